obi_debug_master_arbiter: RTL and testbench

- Shares the single debug-subsystem OBI master port (system bus access / abstract-command path) between NUM_REQ requesters, e.g. the debug module master and a trace/DMA agent.
- Round-robin arbitration with an address-phase lock, so OBI stability rules hold on the shared port.
- A tracked outstanding-transaction queue routes each rvalid/rdata back to the requester that issued it.
- Sits between the requester masters and the system bus crossbar input.

---
 rtl/obi_debug_master_arbiter_if.sv | 37 +++
 rtl/obi_debug_master_arbiter.sv | 130 +++++++++++++
 tb/tb_obi_debug_master_arbiter.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/obi_debug_master_arbiter_if.sv
// Shared OBI types and the bus bundle for the debug master arbiter.
//   obi_req_t  : address phase (req, we, addr, be, wdata)
//   obi_resp_t : response (gnt, rvalid, rdata)
//   interface  : NUM_REQ requester ports (req_i/resp_o) plus the shared
//                master port (master_req_o/master_resp_i).
//   modport slave  : arbiter side
//   modport master : environment side (requesters and the system bus)

package obi_debug_master_arbiter_pkg;
    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;
endpackage

interface obi_debug_master_arbiter_if #(
    parameter int NUM_REQ = 2
);
    import obi_debug_master_arbiter_pkg::*;

    obi_req_t  [NUM_REQ-1:0] req_i;
    obi_resp_t [NUM_REQ-1:0] resp_o;
    obi_req_t                master_req_o;
    obi_resp_t               master_resp_i;

    modport slave  (input  req_i, master_resp_i, output resp_o, master_req_o);
    modport master (output req_i, master_resp_i, input  resp_o, master_req_o);
endinterface

// File: rtl/obi_debug_master_arbiter.sv
// Round-robin arbiter sharing one OBI master port between NUM_REQ requesters.
// An address phase that is not granted immediately is locked until granted so
// the shared port stays stable; a FIFO of issuer indices routes each response
// back to the requester that issued it.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus          : requester and shared master OBI signals (slave modport)
//   busy_o       : transactions outstanding or an address phase locked
//   err_o        : sticky, set by an rvalid with nothing outstanding
//   err_clr_i    : clears err_o (a coincident new error wins)
//
//   state  | meaning
//   IDLE   | free to pick a requester round-robin from rr_ptr
//   LOCKED | an ungranted address phase from sel_q is held on the master port

module obi_debug_master_arbiter
    import obi_debug_master_arbiter_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    obi_debug_master_arbiter_if.slave bus,
    output logic                      busy_o,
    output logic                      err_o,
    input  logic                      err_clr_i
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       rr_ptr_q, sel_q, sel, pick, cand;
    logic                   found;
    logic [IDX_W-1:0]       id_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]       count_q;
    logic                   err_q;
    obi_req_t               mreq;
    obi_resp_t [NUM_REQ-1:0] resp;
    logic                   issue_ok, push, pop, orphan;

    // A pop in this cycle does not open a slot until the next cycle.
    assign issue_ok = count_q < CNT_W'(MAX_OUTSTANDING);

    // First requesting index at or above rr_ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = rr_ptr_q;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!found && bus.req_i[cand].req) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel     = pick;
        mreq    = '0;
        case (state_q)
            IDLE: begin
                if (issue_ok && found) mreq = bus.req_i[pick];
                if (mreq.req && !bus.master_resp_i.gnt) state_d = LOCKED;
            end
            LOCKED: begin
                // Mirrors the owner even if it drops req, so the port follows it to 0.
                sel  = sel_q;
                mreq = bus.req_i[sel_q];
                if (bus.master_resp_i.gnt || !mreq.req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign push   = mreq.req & bus.master_resp_i.gnt;
    assign pop    = bus.master_resp_i.rvalid & (count_q != '0);
    assign orphan = bus.master_resp_i.rvalid & (count_q == '0);

    always_comb begin
        resp           = '0;
        resp[sel].gnt  = push;
        if (pop) begin
            resp[id_q[rd_ptr_q]].rvalid = 1'b1;
            resp[id_q[rd_ptr_q]].rdata  = bus.master_resp_i.rdata;
        end
    end

    // Outputs are forced quiet while reset is held, even if requesters keep req up.
    assign bus.master_req_o = rst_i ? '0 : mreq;
    assign bus.resp_o       = rst_i ? '0 : resp;
    assign busy_o           = (count_q != '0) | (state_q == LOCKED);
    assign err_o            = err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) id_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) sel_q <= pick;
            if (push) begin
                id_q[wr_ptr_q] <= sel;
                wr_ptr_q <= (wr_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
                rr_ptr_q <= (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (orphan)         err_q <= 1'b1;
            else if (err_clr_i) err_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_obi_debug_master_arbiter.sv
// Directed scenarios followed by a randomized run, all checked cycle by cycle
// against a queue-based reference model of the arbiter.

module tb_obi_debug_master_arbiter;
    import obi_debug_master_arbiter_pkg::*;

    localparam int N    = 2;
    localparam int MAXO = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, err, err_clr;

    obi_debug_master_arbiter_if #(.NUM_REQ(N)) bus ();

    obi_debug_master_arbiter #(.NUM_REQ(N), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .bus       (bus),
        .busy_o    (busy),
        .err_o     (err),
        .err_clr_i (err_clr)
    );

    always #5 clk = ~clk;

    int vecs   = 0;
    int misses = 0;

    // reference model state
    int mq[$];
    int rr;
    bit lk;
    int lsel;
    bit merr;
    bit last_gnt [N];

    obi_req_t             cap_mreq;
    obi_resp_t [N-1:0]    cap_resp;
    logic                 cap_busy, cap_err;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vecs++;
        assert (obs === exp) else begin
            misses++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        rr   = 0;
        lk   = 0;
        lsel = 0;
        merr = 0;
        for (int i = 0; i < N; i++) last_gnt[i] = 0;
    endtask

    task automatic model_eval();
        obi_req_t          em;
        obi_resp_t [N-1:0] er;
        int                sel;
        bit                hs, ok, rv;
        cap_mreq = bus.master_req_o;
        cap_resp = bus.resp_o;
        cap_busy = busy;
        cap_err  = err;
        em  = '0;
        er  = '0;
        sel = -1;
        ok  = mq.size() < MAXO;
        rv  = bus.master_resp_i.rvalid;
        if (lk) sel = lsel;
        else if (ok) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (rr + k) % N;
                if (bus.req_i[j].req) begin
                    sel = j;
                    break;
                end
            end
        end
        if (sel >= 0) em = bus.req_i[sel];
        hs = em.req && bus.master_resp_i.gnt;
        if (sel >= 0) er[sel].gnt = hs;
        if (rv && mq.size() > 0) begin
            er[mq[0]].rvalid = 1'b1;
            er[mq[0]].rdata  = bus.master_resp_i.rdata;
        end
        chk("master_req", cap_mreq, em);
        chk("resp", cap_resp, er);
        chk("busy", cap_busy, (mq.size() != 0) || lk);
        chk("err", cap_err, merr);
        // advance: responses refer to earlier issues, so pop before push
        if (rv && mq.size() == 0) merr = 1;
        else if (err_clr) merr = 0;
        if (rv && mq.size() > 0) void'(mq.pop_front());
        if (hs) begin
            mq.push_back(sel);
            rr = (sel + 1) % N;
        end
        if (lk) begin
            if (hs || !em.req) lk = 0;
        end else if (sel >= 0 && em.req && !hs) begin
            lk   = 1;
            lsel = sel;
        end
        for (int i = 0; i < N; i++) last_gnt[i] = (sel == i) && hs;
    endtask

    task automatic tick();
        @(negedge clk);
        model_eval();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit r, input bit we, input logic [31:0] a,
                           input logic [31:0] wd);
        bus.req_i[i] = '{req: r, we: we, addr: a, be: 4'hF, wdata: wd};
    endtask

    task automatic bus_drive(input bit g, input bit rv, input logic [31:0] rd);
        bus.master_resp_i = '{gnt: g, rvalid: rv, rdata: rd};
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && mq.size() > 0; i++) begin
            bus_drive(1'b0, 1'b1, 32'h0BAD_0000 + i);
            tick();
        end
        bus_drive(1'b0, 1'b0, '0);
        chk("drain_empty", mq.size(), 0);
    endtask

    initial begin
        bus.req_i         = '0;
        bus.master_resp_i = '0;
        err_clr           = 1'b0;
        model_reset();

        // reset values
        #12;
        chk("rst_mreq", bus.master_req_o, '0);
        chk("rst_resp", bus.resp_o, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        // single requester read
        set_req(1, 1, 0, 32'h1A00_0010, '0);
        bus_drive(1'b1, 1'b0, '0);
        tick();
        chk("t1_gnt1", cap_resp[1].gnt, 1'b1);
        chk("t1_r0_quiet", cap_resp[0], '0);
        set_req(1, 0, 0, '0, '0);
        bus_drive(1'b0, 1'b0, '0);
        tick();
        bus_drive(1'b0, 1'b1, 32'hDEAD_BEEF);
        tick();
        chk("t1_rvalid1", cap_resp[1].rvalid, 1'b1);
        chk("t1_rdata1", cap_resp[1].rdata, 32'hDEAD_BEEF);
        chk("t1_r0_quiet2", cap_resp[0], '0);
        bus_drive(1'b0, 1'b0, '0);
        tick();
        chk("t1_idle", cap_busy, 1'b0);

        // both requesting, gnt always high, rvalid one cycle after each gnt
        set_req(0, 1, 0, 32'h0000_1000, '0);
        set_req(1, 1, 0, 32'h0000_2000, '0);
        for (int k = 0; k < 6; k++) begin
            bus_drive(1'b1, k > 0, 32'h5000 + k);
            tick();
            chk("t2_gnt_order", cap_resp[k % 2].gnt, 1'b1);
            chk("t2_gnt_other", cap_resp[(k + 1) % 2].gnt, 1'b0);
            if (k > 0) chk("t2_route", cap_resp[(k - 1) % 2].rvalid, 1'b1);
        end
        set_req(0, 0, 0, '0, '0);
        set_req(1, 0, 0, '0, '0);
        drain();

        // address-phase lock while gnt withheld
        set_req(0, 1, 1, 32'hA0A0_0040, 32'h1234_5678);
        bus_drive(1'b0, 1'b0, '0);
        for (int k = 0; k < 3; k++) begin
            if (k == 1) set_req(1, 1, 0, 32'hB0B0_0080, '0);
            tick();
            chk("t3_addr", cap_mreq.addr, 32'hA0A0_0040);
            chk("t3_wdata", cap_mreq.wdata, 32'h1234_5678);
            chk("t3_no_gnt1", cap_resp[1].gnt, 1'b0);
        end
        bus_drive(1'b1, 1'b0, '0);
        tick();
        chk("t3_gnt0", cap_resp[0].gnt, 1'b1);
        chk("t3_gnt1_wait", cap_resp[1].gnt, 1'b0);
        set_req(0, 0, 0, '0, '0);
        tick();
        chk("t3_gnt1", cap_resp[1].gnt, 1'b1);
        set_req(1, 0, 0, '0, '0);
        bus_drive(1'b0, 1'b0, '0);
        drain();

        // fill the queue, third request must wait for a pop plus one cycle
        bus_drive(1'b1, 1'b0, '0);
        set_req(0, 1, 0, 32'h0000_0100, '0);
        tick();
        set_req(0, 0, 0, '0, '0);
        set_req(1, 1, 0, 32'h0000_0200, '0);
        tick();
        set_req(1, 0, 0, '0, '0);
        set_req(0, 1, 0, 32'h0000_0300, '0);
        tick();
        chk("t4_full1", cap_mreq.req, 1'b0);
        tick();
        chk("t4_full2", cap_mreq.req, 1'b0);
        bus_drive(1'b1, 1'b1, 32'hCAFE_0001);
        tick();
        chk("t4_pop_same", cap_mreq.req, 1'b0);
        chk("t4_pop_r0", cap_resp[0].rvalid, 1'b1);
        bus_drive(1'b1, 1'b0, '0);
        tick();
        chk("t4_issue", cap_mreq.req, 1'b1);
        chk("t4_gnt0", cap_resp[0].gnt, 1'b1);
        set_req(0, 0, 0, '0, '0);
        bus_drive(1'b0, 1'b0, '0);
        drain();

        // orphan response, clear, and set-wins-over-clear
        bus_drive(1'b0, 1'b1, 32'h0000_0EEE);
        tick();
        chk("t5_no_rvalid", {cap_resp[0].rvalid, cap_resp[1].rvalid}, 2'b00);
        bus_drive(1'b0, 1'b0, '0);
        tick();
        chk("t5_err_set", cap_err, 1'b1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();
        chk("t5_err_clr", cap_err, 1'b0);
        err_clr = 1'b1;
        bus_drive(1'b0, 1'b1, '0);
        tick();
        err_clr = 1'b0;
        bus_drive(1'b0, 1'b0, '0);
        tick();
        chk("t5_set_wins", cap_err, 1'b1);

        // async reset with two outstanding
        bus_drive(1'b1, 1'b0, '0);
        set_req(0, 1, 0, 32'h0000_0400, '0);
        tick();
        set_req(0, 0, 0, '0, '0);
        set_req(1, 1, 0, 32'h0000_0500, '0);
        tick();
        set_req(1, 0, 0, '0, '0);
        set_req(0, 1, 0, 32'h0000_0600, '0);
        #3 rst = 1'b1;
        #1;
        chk("t6_mreq", bus.master_req_o, '0);
        chk("t6_resp", bus.resp_o, '0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_err", err, 1'b0);
        bus.req_i = '0;
        bus_drive(1'b0, 1'b0, '0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        bus_drive(1'b0, 1'b1, 32'h0000_0777);
        tick();
        bus_drive(1'b0, 1'b0, '0);
        tick();
        chk("t6_orphan_err", cap_err, 1'b1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!bus.req_i[i].req || last_gnt[i]) begin
                    set_req(i, $urandom_range(0, 2) != 0, 1'($urandom), $urandom, $urandom);
                end else if ($urandom_range(0, 15) == 0) begin
                    bus.req_i[i].req = 1'b0;
                end
            end
            bus_drive(1'($urandom),
                      ($urandom_range(0, 1) == 1) && (mq.size() > 0 || $urandom_range(0, 19) == 0),
                      $urandom);
            err_clr = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, misses);
        $finish;
    end
endmodule
